// File: rtl/port_freq_meter.sv
// port_freq_meter: input-side frequency meter for a WIDTH-bit pin port.
// Counts rising edges on one selected pin over a GATE_TIME-cycle window and
// returns the count plus a synchronized port snapshot over valid/ready.
// Optional macro PORT_FREQ_METER_CONTINUOUS_EN: back-to-back windows after
// the first start, with a sticky 'overrun' output for unread results.
module port_freq_meter #(
  parameter int WIDTH     = 16,
  parameter int GATE_TIME = 10000000,
  parameter int CNT_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] port_in,
  input  logic [3:0]       sel,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] snapshot,
  output logic             overflow,
  output logic             valid,
`ifdef PORT_FREQ_METER_CONTINUOUS_EN
  output logic             overrun,
`endif
  input  logic             ready
);

  // Gate counter must hold GATE_TIME without truncation.
  localparam int GW = $clog2(GATE_TIME + 1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [4:0]       WIDTH_L   = 5'(WIDTH);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
`ifdef PORT_FREQ_METER_CONTINUOUS_EN
  logic             overrun_q, overrun_d;
`endif

  logic [WIDTH-1:0] sel_mask;
  logic             rise;
  logic             handshake;
  logic [CNT_W-1:0] acc_next;
  logic             acc_ovf_next;

  // Edge detect on the latched bit: synchronized level high, previous level low.
  always_comb begin
    sel_mask = ONE << sel_q;
    rise     = (|(sync2_q & sel_mask)) & ~(|(prev_q & sel_mask));
  end

  // Pin path: two-flop synchronizer, then a prev copy for edge detection.
  // prev follows sync every cycle, so the ARM cycle leaves prev equal to the
  // current level and a pin already high is not counted as an edge.
  always_comb begin
    sync1_d = port_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Saturating accumulator step; the flag records that a real edge was lost.
  always_comb begin
    acc_next     = acc_q;
    acc_ovf_next = acc_ovf_q;
    if (rise) begin
      if (acc_q == CNT_MAX) begin
        acc_ovf_next = 1'b1;
      end else begin
        acc_next = acc_q + 1'b1;
      end
    end
  end

  // Measurement sequencer plus result register and handshake.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gate_d    = gate_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    count_d   = count_q;
    snap_d    = snap_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
`ifdef PORT_FREQ_METER_CONTINUOUS_EN
    overrun_d = overrun_q;
`endif
    handshake = valid_q & ready;

    if (handshake) begin
      valid_d = 1'b0;
`ifdef PORT_FREQ_METER_CONTINUOUS_EN
      overrun_d = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = ({1'b0, sel} >= WIDTH_L) ? 4'd0 : sel;
          state_d = ARM;
        end
      end
      ARM: begin
        gate_d    = '0;
        acc_d     = '0;
        acc_ovf_d = 1'b0;
        state_d   = GATE;
      end
      GATE: begin
        acc_d     = acc_next;
        acc_ovf_d = acc_ovf_next;
        if (gate_q == GATE_LAST) begin
          count_d = acc_next;
          snap_d  = sync2_q;
          ovf_d   = acc_ovf_next;
          valid_d = 1'b1;
`ifdef PORT_FREQ_METER_CONTINUOUS_EN
          if (valid_q && !ready) begin
            overrun_d = 1'b1;
          end
          state_d = ARM;
`else
          state_d = HOLD;
`endif
        end else begin
          gate_d = gate_q + 1'b1;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any measurement in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      gate_q    <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      count_q   <= '0;
      snap_q    <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef PORT_FREQ_METER_CONTINUOUS_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      gate_q    <= gate_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      count_q   <= count_d;
      snap_q    <= snap_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
`ifdef PORT_FREQ_METER_CONTINUOUS_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign count    = count_q;
  assign snapshot = snap_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
`ifdef PORT_FREQ_METER_CONTINUOUS_EN
  assign overrun  = overrun_q;
`endif

endmodule

// File: doc/port_freq_meter.md
Name: port_freq_meter

Overview:
- Input-side counterpart of the 16-bit port counter: samples a 16-bit input port and counts rising edges on one selected bit over a fixed gate window.
- Reports the edge count plus a snapshot of the port through a valid/ready result interface.
- Sits at the board-pin boundary and drives downstream display or serial logic.

Parameters:
- WIDTH, 16, input port width; range 2..16.
- GATE_TIME, 10000000, gate window length in clk cycles; must be >= 1.
- CNT_W, 24, edge counter and result width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- port_in  input  WIDTH  asynchronous input pins.
- sel  input  4  index of the bit to measure; sampled on start; values >= WIDTH select bit 0.
- start  input  1  one-cycle request to begin a measurement; honoured only in IDLE.
- busy  output  1  high in ARM, GATE and HOLD.
- count  output  CNT_W  rising-edge count of the last completed window.
- snapshot  output  WIDTH  synchronized port value on the last gate cycle.
- overflow  output  1  edge count saturated during the last window.
- valid  output  1  result available.
- ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; busy, valid, overflow = 0; count, snapshot = 0.
  - Synchronizer and edge registers = 0; gate counter = 0.
  - Reset mid-measurement aborts it; no result is produced.
- Input path:
  - 2-flop synchronizer on all WIDTH bits, then one prev register for edge detection.
  - A pin change is visible at the edge detector 2 cycles later.
  - Rising edge = sync[sel_q] == 1 and prev[sel_q] == 0.
- FSM:
  - IDLE: on start, latch sel into sel_q and go to ARM. start in any other state is ignored.
  - ARM: lasts 1 cycle. Clears the edge accumulator and gate counter. prev is loaded from sync[sel_q], so a level already high is not counted. Next state is GATE.
  - GATE: exactly GATE_TIME cycles, gate counter 0..GATE_TIME-1.
    - Each cycle with a rising edge increments the accumulator.
    - An edge on the final gate cycle is counted.
    - The accumulator saturates at 2^CNT_W-1 and sets an internal overflow flag; it never wraps.
    - At gate counter == GATE_TIME-1: next cycle count = final accumulator, snapshot = sync, overflow = flag, valid = 1; state goes to HOLD.
  - HOLD: count, snapshot, overflow and valid are stable.
    - The handshake completes on the cycle where valid && ready; next cycle valid = 0 and state = IDLE.
    - count, snapshot and overflow hold their values until the next result.
- Latency: start at cycle t; ARM at t+1; GATE t+2 .. t+1+GATE_TIME; valid first high at t+2+GATE_TIME.
- ready while valid = 0 has no effect.
- sel changes after start have no effect until the next start.
- Widths:
  - gate counter is ceil(log2(GATE_TIME+1)) bits;
  - all compares are unsigned;
  - no truncation of GATE_TIME.

Optional Feature:
- Macro PORT_FREQ_METER_CONTINUOUS_EN.
- Defined:
  - After GATE the FSM goes directly to ARM, with no HOLD and no start needed after the first.
  - Windows repeat back-to-back with a 1-cycle ARM gap.
  - Each result overwrites count, snapshot and overflow and sets valid.
  - valid clears on valid && ready, or on reset.
  - If a new result arrives while valid is still 1, sticky output overrun (1 bit, reset 0) is set; it clears on the next accepted handshake.
  - busy stays 1 after the first start.
- Undefined: single-shot behaviour as above; the overrun port does not exist.

Test Plan (GATE_TIME=100, CNT_W=8, WIDTH=16):
- Reset, then idle for 20 cycles -> busy=0, valid=0, count=0, snapshot=0, overflow=0.
- sel=3, port_in[3] toggling with period 10 cycles, start pulse at cycle t -> valid at t+102, count=10, overflow=0; ready=1 -> valid=0 next cycle, state IDLE.
- port_in[5] held high before start, sel=5, no further edges -> count=0; snapshot[5]=1.
- sel=0 toggling every cycle (toggle period 2) and CNT_W=5 -> accumulator saturates, count=31, overflow=1.
- start pulses repeated during GATE and HOLD -> ignored; exactly one result.
- ready held low for 50 cycles -> values stable; no new measurement.
- rst asserted at gate cycle 50, then released -> outputs 0 immediately; a new start gives a correct count.
- Single edge on the final gate cycle -> counted; count=1.
- CONTINUOUS_EN, 10-cycle toggle, ready=1 -> results every 101 cycles, count=10 each.
- CONTINUOUS_EN, ready=0 -> overrun=1 after the second result; a later ready handshake clears it.
